// File: rtl/sram_bist_pkg.sv
// Shared definitions for the March C- SRAM BIST controller: element encoding,
// per-element operation table, sequencer states and result widths.
package sram_bist_pkg;

    localparam int unsigned FAIL_CNT_W = 12;

    typedef enum logic [2:0] {
        E_W0       = 3'd0,
        E_R0_W1    = 3'd1,
        E_R1_W0    = 3'd2,
        E_R0_W1_DN = 3'd3,
        E_R1_W0_DN = 3'd4,
        E_R0_FINAL = 3'd5
    } element_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } op_kind_t;

    // pol = 0 selects the all-zero word, 1 the all-ones word
    typedef struct packed {
        logic     down;
        op_kind_t op0_kind;
        logic     op0_pol;
        op_kind_t op1_kind;
        logic     op1_pol;
        logic [1:0] op_cnt;
    } elem_desc_t;

    // Rows 6 and 7 are unreachable; they keep the index range total.
    localparam elem_desc_t ELEM_TABLE [8] = '{
        '{1'b0, OP_WR, 1'b0, OP_WR, 1'b0, 2'd1},
        '{1'b0, OP_RD, 1'b0, OP_WR, 1'b1, 2'd2},
        '{1'b0, OP_RD, 1'b1, OP_WR, 1'b0, 2'd2},
        '{1'b1, OP_RD, 1'b0, OP_WR, 1'b1, 2'd2},
        '{1'b1, OP_RD, 1'b1, OP_WR, 1'b0, 2'd2},
        '{1'b0, OP_RD, 1'b0, OP_WR, 1'b0, 2'd1},
        '{1'b0, OP_WR, 1'b0, OP_WR, 1'b0, 2'd1},
        '{1'b0, OP_WR, 1'b0, OP_WR, 1'b0, 2'd1}
    };

endpackage

// File: rtl/sram_bist_cmp.sv
// Read-data check stage: registers the expectation of each issued read and
// compares it against the macro output one edge later, capturing the first failure.
module sram_bist_cmp
    import sram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  rd_issue,
    input  logic [DATA_WIDTH-1:0] rd_exp,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [2:0]            rd_elem,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_element,
    output logic [FAIL_CNT_W-1:0] fail_count
);

    logic                  chk_valid;
    logic [DATA_WIDTH-1:0] chk_exp;
    logic [ADDR_WIDTH-1:0] chk_addr;
    logic [2:0]            chk_elem;
    logic                  mismatch;

    assign mismatch = chk_valid && (dout != chk_exp);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            chk_valid    <= 1'b0;
            chk_exp      <= '0;
            chk_addr     <= '0;
            chk_elem     <= '0;
            fail         <= 1'b0;
            fail_addr    <= '0;
            fail_element <= '0;
            fail_count   <= '0;
        end else begin
            chk_valid <= rd_issue;
            chk_exp   <= rd_exp;
            chk_addr  <= rd_addr;
            chk_elem  <= rd_elem;
            if (mismatch) begin
                fail <= 1'b1;
                if (fail_count != '1) begin
                    fail_count <= fail_count + 1'b1;
                end
                if (!fail) begin
                    fail_addr    <= chk_addr;
                    fail_element <= chk_elem;
                end
            end
        end
    end

endmodule

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST sequencer driving the SRAM macro BIST port; one start pulse runs
// all six elements back to back and reports pass/fail with the first failing location.
module sram_march_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  A_BIST_CLK,
    input  logic                  A_BIST_RST,
    input  logic                  start,
    output logic                  A_BIST_EN,
    output logic                  A_BIST_MEN,
    output logic                  A_BIST_WEN,
    output logic                  A_BIST_REN,
    output logic [ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [DATA_WIDTH-1:0] A_BIST_BM,
    input  logic [DATA_WIDTH-1:0] A_DOUT,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_element,
    output logic [FAIL_CNT_W-1:0] fail_count
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = '1;

    state_t                state, nxt_state;
    element_t              elem, nxt_elem, inc_elem;
    logic [ADDR_WIDTH-1:0] addr, nxt_addr;
    logic                  op_idx, nxt_op_idx;
    logic                  start_ok;
    logic                  last_op, last_addr;
    logic                  nxt_run, nxt_wr, nxt_pol;
    logic [2:0]            port_elem;
    logic [DATA_WIDTH-1:0] port_exp;

    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign inc_elem  = element_t'(elem + 3'd1);
    assign last_op   = (ELEM_TABLE[elem].op_cnt == 2'd1) || op_idx;
    assign last_addr = ELEM_TABLE[elem].down ? (addr == '0) : (addr == ADDR_TOP);

    // The counters always name the operation presented on the port; the port
    // registers are loaded from the next-state values so they change with them.
    always_comb begin
        nxt_state  = state;
        nxt_elem   = elem;
        nxt_addr   = addr;
        nxt_op_idx = op_idx;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    nxt_state  = ST_RUN;
                    nxt_elem   = E_W0;
                    nxt_addr   = '0;
                    nxt_op_idx = 1'b0;
                end
            end
            ST_RUN: begin
                if (!last_op) begin
                    nxt_op_idx = 1'b1;
                end else begin
                    nxt_op_idx = 1'b0;
                    if (!last_addr) begin
                        nxt_addr = ELEM_TABLE[elem].down ? addr - 1'b1 : addr + 1'b1;
                    end else if (elem == E_R0_FINAL) begin
                        nxt_state = ST_DRAIN;
                    end else begin
                        nxt_elem = inc_elem;
                        nxt_addr = ELEM_TABLE[inc_elem].down ? ADDR_TOP : '0;
                    end
                end
            end
            ST_DRAIN: nxt_state = ST_DONE;
            default:  nxt_state = ST_IDLE;
        endcase
    end

    always_comb begin
        nxt_run = (nxt_state == ST_RUN);
        if (nxt_op_idx) begin
            nxt_wr  = (ELEM_TABLE[nxt_elem].op1_kind == OP_WR);
            nxt_pol = ELEM_TABLE[nxt_elem].op1_pol;
        end else begin
            nxt_wr  = (ELEM_TABLE[nxt_elem].op0_kind == OP_WR);
            nxt_pol = ELEM_TABLE[nxt_elem].op0_pol;
        end
    end

    always_ff @(posedge A_BIST_CLK) begin
        if (A_BIST_RST) begin
            state       <= ST_IDLE;
            elem        <= E_W0;
            addr        <= '0;
            op_idx      <= 1'b0;
            A_BIST_EN   <= 1'b0;
            A_BIST_MEN  <= 1'b0;
            A_BIST_WEN  <= 1'b0;
            A_BIST_REN  <= 1'b0;
            A_BIST_ADDR <= '0;
            A_BIST_DIN  <= '0;
            A_BIST_BM   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            port_elem   <= '0;
            port_exp    <= '0;
        end else begin
            state       <= nxt_state;
            elem        <= nxt_elem;
            addr        <= nxt_addr;
            op_idx      <= nxt_op_idx;
            A_BIST_EN   <= (nxt_state == ST_RUN) || (nxt_state == ST_DRAIN);
            busy        <= (nxt_state == ST_RUN) || (nxt_state == ST_DRAIN);
            done        <= (nxt_state == ST_DONE);
            A_BIST_MEN  <= nxt_run;
            A_BIST_WEN  <= nxt_run && nxt_wr;
            A_BIST_REN  <= nxt_run && !nxt_wr;
            A_BIST_ADDR <= nxt_run ? nxt_addr : '0;
            A_BIST_DIN  <= (nxt_run && nxt_wr) ? {DATA_WIDTH{nxt_pol}} : '0;
            A_BIST_BM   <= (nxt_run && nxt_wr) ? '1 : '0;
            port_elem   <= nxt_elem;
            port_exp    <= {DATA_WIDTH{nxt_pol}};
        end
    end

    sram_bist_cmp #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_cmp (
        .clk          (A_BIST_CLK),
        .rst          (A_BIST_RST),
        .clr          (start_ok),
        .rd_issue     (A_BIST_REN),
        .rd_exp       (port_exp),
        .rd_addr      (A_BIST_ADDR),
        .rd_elem      (port_elem),
        .dout         (A_DOUT),
        .fail         (fail),
        .fail_addr    (fail_addr),
        .fail_element (fail_element),
        .fail_count   (fail_count)
    );

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Scoreboard bench for sram_march_bist_ctrl against a behavioural macro with
// optional stuck-at faults and a march-level reference model.
module tb_sram_march_bist_ctrl;

    localparam int AW    = 8;
    localparam int DW    = 64;
    localparam int DEPTH = 256;
    localparam int NOPS  = 10 * DEPTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN;
    logic [AW-1:0] A_BIST_ADDR;
    logic [DW-1:0] A_BIST_DIN, A_BIST_BM;
    logic [DW-1:0] A_DOUT = '0;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_element;
    logic [11:0]   fail_count;
    logic [165:0]  all_out;

    always #5 clk = ~clk;

    sram_march_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .A_BIST_CLK(clk), .A_BIST_RST(rst), .start(start),
        .A_BIST_EN(A_BIST_EN), .A_BIST_MEN(A_BIST_MEN), .A_BIST_WEN(A_BIST_WEN),
        .A_BIST_REN(A_BIST_REN), .A_BIST_ADDR(A_BIST_ADDR), .A_BIST_DIN(A_BIST_DIN),
        .A_BIST_BM(A_BIST_BM), .A_DOUT(A_DOUT), .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_element(fail_element), .fail_count(fail_count)
    );

    assign all_out = {A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_DIN,
                      A_BIST_BM, busy, done, fail, fail_addr, fail_element, fail_count};

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned cyc     = 0;
    int unsigned start_edge = 0;
    int unsigned en_cnt  = 0;
    logic        done_q  = 1'b0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural macro; the fault corrupts read data at one address only.
    logic [DW-1:0] mem [DEPTH];
    logic          fault_on = 1'b0;
    logic [AW-1:0] fault_addr = '0;
    logic [DW-1:0] sa1_mask = '0;
    logic [DW-1:0] sa0_mask = '0;

    function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] v);
        if (fault_on && a == fault_addr) return (v | sa1_mask) & ~sa0_mask;
        return v;
    endfunction

    always @(posedge clk) begin
        if (A_BIST_EN && A_BIST_MEN) begin
            if (A_BIST_WEN) mem[A_BIST_ADDR] <= (mem[A_BIST_ADDR] & ~A_BIST_BM) | (A_BIST_DIN & A_BIST_BM);
            if (A_BIST_REN) A_DOUT <= faulty(A_BIST_ADDR, mem[A_BIST_ADDR]);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    typedef struct {
        logic          fail;
        logic [AW-1:0] addr;
        logic [2:0]    elem;
        int unsigned   cnt;
        int unsigned   done_cyc;
    } res_t;

    op_t  exp_ops [$];
    res_t exp_res [$];

    task automatic push_op(input logic we, input int a, input logic [DW-1:0] d);
        op_t o;
        o.we = we;
        o.addr = AW'(a);
        o.data = d;
        exp_ops.push_back(o);
    endtask

    // Walks March C- element by element over a private array, as the spec describes it.
    task automatic predict_run(input int unsigned k);
        logic [DW-1:0] m [DEPTH];
        logic [DW-1:0] want, got;
        int            a;
        res_t          r;
        r.fail = 1'b0; r.addr = '0; r.elem = '0; r.cnt = 0; r.done_cyc = k + NOPS + 1;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < DEPTH; i++) begin
                a = (e == 3 || e == 4) ? DEPTH - 1 - i : i;
                want = (e == 2 || e == 4) ? '1 : '0;
                if (e == 0) begin
                    push_op(1'b1, a, '0);
                    m[a] = '0;
                end else begin
                    push_op(1'b0, a, '0);
                    got = faulty(AW'(a), m[a]);
                    if (got != want) begin
                        if (!r.fail) begin r.addr = AW'(a); r.elem = 3'(e); end
                        r.fail = 1'b1;
                        if (r.cnt < 4095) r.cnt++;
                    end
                    if (e != 5) begin
                        push_op(1'b1, a, ~want);
                        m[a] = ~want;
                    end
                end
            end
        end
        exp_res.push_back(r);
    endtask

    // Op monitor: every enabled port cycle must be the next expected march op.
    always @(negedge clk) begin : op_mon
        op_t o;
        if (!rst && A_BIST_MEN) begin
            if (exp_ops.size() == 0) begin
                chk("op_unexpected", 192'(A_BIST_ADDR) | 192'h1_0000, 192'(A_BIST_ADDR));
            end else begin
                o = exp_ops.pop_front();
                chk("port_op",
                    192'({A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_BM, A_BIST_WEN ? A_BIST_DIN : {DW{1'b0}}}),
                    192'({o.we, !o.we, o.addr, o.we ? {DW{1'b1}} : {DW{1'b0}}, o.we ? o.data : {DW{1'b0}}}));
            end
        end
    end

    // Result monitor: compares the report whenever done rises.
    always @(negedge clk) begin : res_mon
        res_t r;
        if (rst) begin
            en_cnt = 0;
            done_q = 1'b0;
        end else begin
            if (A_BIST_EN) en_cnt++;
            if (done && !done_q) begin
                if (exp_res.size() == 0) begin
                    chk("done_unexpected", 192'(done), 192'(0));
                end else begin
                    r = exp_res.pop_front();
                    chk("fail", 192'(fail), 192'(r.fail));
                    chk("fail_addr", 192'(fail_addr), 192'(r.addr));
                    chk("fail_element", 192'(fail_element), 192'(r.elem));
                    chk("fail_count", 192'(fail_count), 192'(r.cnt));
                    chk("done_cycle", 192'(cyc), 192'(r.done_cyc));
                    chk("en_cycles", 192'(en_cnt), 192'(NOPS + 1));
                end
                en_cnt = 0;
            end
            done_q = done;
        end
    end

    task automatic issue_start();
        @(negedge clk);
        start = 1'b1;
        start_edge = cyc + 1;
        predict_run(start_edge);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int unsigned n = 0;
        while (!done && n < NOPS + 50) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_total++;
            $display("FAIL %s_timeout: done=0 after %0d cycles, expected 1", tag, n);
        end
        @(negedge clk);
    endtask

    task automatic set_fault(input logic [AW-1:0] a, input int b, input logic sa1);
        logic [DW-1:0] one = 1;
        fault_on = 1'b1;
        fault_addr = a;
        sa1_mask = sa1 ? (one << b) : '0;
        sa0_mask = sa1 ? '0 : (one << b);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 192'(all_out), 192'(0));
        rst = 1'b0;
        while (cyc < 9) @(negedge clk);

        // fault-free run, start sampled at edge 10
        issue_start();
        wait_done("clean");

        // spec example: bit 5 of 0x3A stuck at 1
        set_fault(8'h3A, 5, 1'b1);
        issue_start();
        wait_done("sa1_3a");
        chk("ex_fail", 192'(fail), 192'(1));
        chk("ex_fail_addr", 192'(fail_addr), 192'(8'h3A));
        chk("ex_fail_element", 192'(fail_element), 192'(1));
        chk("ex_fail_count", 192'(fail_count), 192'(3));

        // random single stuck-at faults
        for (int t = 0; t < 3; t++) begin
            set_fault(AW'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DW - 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 20)) @(negedge clk);
            issue_start();
            wait_done("rand_fault");
        end

        // reset during the run
        fault_on = 1'b0;
        issue_start();
        while (cyc < start_edge + 1000) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_reset_outputs", 192'(all_out), 192'(0));
        exp_ops.delete();
        exp_res.delete();
        rst = 1'b0;
        issue_start();
        wait_done("after_reset");

        // start pulse during RUN is ignored
        issue_start();
        repeat ($urandom_range(100, 2000)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("midrun_busy", 192'({busy, done}), 192'(2'b10));
        wait_done("ignored_start");

        // failing run, then restart from DONE with the fault removed
        set_fault(AW'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DW - 1)), 1'b0);
        issue_start();
        wait_done("fail_before_rerun");
        chk("pre_rerun_fail", 192'(fail), 192'(1));
        fault_on = 1'b0;
        issue_start();
        chk("rerun_cleared", 192'({fail, fail_addr, fail_element, fail_count, done, busy}),
            192'({1'b0, 8'h00, 3'd0, 12'd0, 1'b0, 1'b1}));
        wait_done("rerun");

        chk("ops_drained", 192'(exp_ops.size()), 192'(0));
        chk("results_drained", 192'(exp_res.size()), 192'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
